// File: rtl/control_iluminacion_zonas.sv
// Multi-zone lighting controller: per-zone IDLE/AUTO/FORCED lamp FSM with hold timer,
// darkness detection from night flag or lux threshold, and sticky motion-seen flags.
module control_iluminacion_zonas #(
  parameter int ZONES    = 4,
  parameter int LUX_W    = 8,
  parameter int HOLD_W   = 16,
  parameter int HOLD_CYC = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         night,
  input  logic [LUX_W-1:0]             lux,
  input  logic [LUX_W-1:0]             lux_thresh,
  input  logic [ZONES-1:0]             motion,
  input  logic [ZONES-1:0]             manual_on,
  input  logic [ZONES-1:0]             manual_off,
  output logic [ZONES-1:0]             bulb,
  output logic [ZONES-1:0]             motion_seen,
  output logic [$clog2(ZONES+1)-1:0]   lights_on
);

  localparam int CNT_W = $clog2(ZONES+1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AUTO   = 2'd1,
    ST_FORCED = 2'd2
  } zone_state_e;

  zone_state_e       state_q [ZONES];
  logic [HOLD_W-1:0] timer_q [ZONES];
  logic [ZONES-1:0]  bulb_q;
  logic [ZONES-1:0]  motion_seen_q;
  logic [ZONES-1:0]  motion_seen_d;
  logic              dark_s;
  logic              auto_ok_s;
  logic [CNT_W-1:0]  lights_on_s;

  // Darkness qualifier shared by all zones; lux equal to threshold counts as daylight.
  always_comb begin
    dark_s    = night | (lux < lux_thresh);
    auto_ok_s = enable & dark_s;
  end

  // Per-zone lamp FSM; bulb is updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ZONES; i++) begin
        state_q[i] <= ST_IDLE;
        timer_q[i] <= '0;
      end
      bulb_q <= '0;
    end else begin
      for (int i = 0; i < ZONES; i++) begin
        if (manual_off[i]) begin
          state_q[i] <= ST_IDLE;
          timer_q[i] <= '0;
          bulb_q[i]  <= 1'b0;
        end else if (manual_on[i]) begin
          state_q[i] <= ST_FORCED;
          timer_q[i] <= '0;
          bulb_q[i]  <= 1'b1;
        end else begin
          case (state_q[i])
            ST_IDLE: begin
              if (auto_ok_s && motion[i]) begin
                state_q[i] <= ST_AUTO;
                timer_q[i] <= HOLD_LOAD;
                bulb_q[i]  <= 1'b1;
              end
            end
            ST_AUTO: begin
              // Losing enable or darkness drops the zone before motion can extend it.
              if (!auto_ok_s) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
                bulb_q[i]  <= 1'b0;
              end else if (motion[i]) begin
                timer_q[i] <= HOLD_LOAD;
              end else if (timer_q[i] > HOLD_W'(1)) begin
                timer_q[i] <= timer_q[i] - HOLD_W'(1);
              end else begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
                bulb_q[i]  <= 1'b0;
              end
            end
            ST_FORCED: begin
              state_q[i] <= ST_FORCED;
              bulb_q[i]  <= 1'b1;
            end
            default: begin
              state_q[i] <= ST_IDLE;
              timer_q[i] <= '0;
              bulb_q[i]  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Sticky motion flags: daytime clears and takes priority over new motion.
  always_comb begin
    motion_seen_d = motion_seen_q;
    if (!night) begin
      motion_seen_d = '0;
    end else begin
      motion_seen_d = motion_seen_q | (motion & {ZONES{enable}});
    end
  end

  // Motion-seen register.
  always_ff @(posedge clk) begin
    if (rst) begin
      motion_seen_q <= '0;
    end else begin
      motion_seen_q <= motion_seen_d;
    end
  end

  // Number of lit zones.
  always_comb begin
    lights_on_s = '0;
    for (int i = 0; i < ZONES; i++) begin
      lights_on_s = lights_on_s + CNT_W'(bulb_q[i]);
    end
  end

  assign bulb        = bulb_q;
  assign motion_seen = motion_seen_q;
  assign lights_on   = lights_on_s;

endmodule
